riscv_core: RTL and testbench
=============================

Name: riscv_core

Overview:
- Single-issue, in-order RV32I integer core with a 3-stage pipeline: F (fetch), E (decode/execute), W (memory return/writeback).
- Connects to two external synchronous SRAMs:
  - Instruction SRAM: read-only.
  - Data SRAM: byte-maskable read/write.
- Both SRAMs register address/enables on clk and return data in the following cycle.
- Top-level compute block of the test SoC.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock, all state on rising edge.
- rstn  input  1  reset, asynchronous, active-high (core held in reset while rstn=1).
- ins_a  output  16  instruction byte address (= pc[15:0]); SRAM uses ins_a[15:2].
- ins_e  output  1  instruction read enable.
- ins  input  32  instruction word, valid the cycle after ins_a/ins_e are presented.
- dat_a  output  16  data byte address; SRAM uses dat_a[15:2].
- dat_we  output  4  per-byte write enable.
- dat_wd  output  32  write data, lane-aligned.
- dat_re  output  4  per-byte read enable.
- dat_rd  input  32  read data, valid the cycle after the request.

Behaviour:
- Reset values (while rstn=1): pc=RESET_PC, ins_e=0, dat_we=0, dat_re=0, dat_a=0, dat_wd=0, E/W valid=0, x1..x31=0.
- x0 always reads 0; writes to x0 are dropped.
- F stage:
  - ins_a=pc and ins_e=1 every cycle out of reset.
  - pc<=pc+4, or pc<=target when E redirects.
- E stage:
  - Holds pc_e and vld_e; instruction is the ins input.
  - Decodes LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LB/LH/LW/LBU/LHU, SB/SH/SW, all OP-IMM and OP (incl. SUB, SRA/SRAI, SLT/SLTU).
  - Reads 2 regfile ports asynchronously.
  - Forwards the W-stage write value when W.rd==rs and W writes.
  - ALU arithmetic is 32-bit wrap-around; shifts use the low 5 bits.
- Control transfer, resolved in E:
  - Taken branch/JAL/JALR sets pc<=target and clears vld_e for the next cycle (1 bubble).
  - JALR target=(rs1+imm)&~1; JAL/JALR write pc_e+4.
  - No misalignment trap.
- Data request, driven combinationally from E when vld_e:
  - Address: dat_a=(rs1+imm)[15:0].
  - Byte mask from funct3 and addr[1:0]:
    - Byte: 1<<addr[1:0].
    - Half: 4'b0011<<{addr[1],1'b0}.
    - Word: 4'b1111.
  - Loads assert the mask on dat_re only; stores on dat_we only.
  - Store data replicated across lanes: byte x4, half x2.
  - Misaligned low bits below the access size are ignored.
- W stage:
  - Result from E registered; load result selected from dat_rd by the registered addr[1:0] and funct3, then sign/zero-extended.
  - Regfile written on the clk edge ending W.
  - Load-use needs no stall: W forwards dat_rd-derived data combinationally into E.
- FENCE, ECALL, EBREAK, CSR and unknown opcodes execute as NOP (no writes, no redirect).
- Reset asserted mid-operation:
  - Outstanding requests are dropped immediately.
  - Fetch restarts at RESET_PC the first edge after rstn=0.

Optional Feature:
- Macro ILLEGAL_HALT_EN.
- Defined:
  - An E-stage valid instruction with an opcode outside RV32I (incl. SYSTEM/CSR) sets a sticky halt.
  - Thereafter ins_e=0, pc frozen, no dat_we/dat_re, no regfile writes.
  - Only reset clears the halt.
- Undefined: such instructions are NOPs.

Test Plan:
- Reset release, NOPs at 0x0..0xC -> ins_a=0,4,8,C on consecutive cycles; ins_e=1 from the first cycle after rstn falls.
- ADDI x1,x0,5; ADDI x2,x1,-7; SUB x3,x1,x2 back-to-back -> x1=5, x2=0xFFFFFFFE, x3=7 (forwarding, no stall).
- SW x1,0x10(x0); SB x2,0x13(x0); LW x4,0x10(x0); ADD x5,x4,x0:
  - SW drives dat_we=1111, dat_a=0x10, dat_wd=5.
  - SB drives dat_we=1000, dat_wd=0xFEFEFEFE.
  - Then x4=x5=0xFE000005.
- LB/LBU from byte 0x13 holding 0xFE -> 0xFFFFFFFE / 0x000000FE; LH at 0x12 -> 0xFFFFFE00.
- BLTU x1,x2,+8 with x1=5, x2=0xFFFFFFFE:
  - Taken; the instruction at +4 is squashed (no regfile write).
  - Next ins_a=target.
- JAL x1,+0x20 at pc 0x40 -> x1=0x44, ins_a=0x60.
- JALR x0,x1,1 with x1=0x44 -> ins_a=0x44.
- With ILLEGAL_HALT_EN, word 0x00000073 (ECALL) -> ins_e drops to 0 next cycle and stays 0 until reset.

Source files
------------

// File: rtl/riscv_core.sv
`default_nettype none
// riscv_core: single-issue 3-stage (F/E/W) RV32I core driving synchronous instruction and data SRAMs.
// Optional macro ILLEGAL_HALT_EN: a non-RV32I opcode in E halts the core until reset.
module riscv_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   output logic [15:0] ins_a,
   output logic        ins_e,
   input  logic [31:0] ins,
   output logic [15:0] dat_a,
   output logic [3:0]  dat_we,
   output logic [31:0] dat_wd,
   output logic [3:0]  dat_re,
   input  logic [31:0] dat_rd
);
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LD    = 7'b0000011;
   localparam logic [6:0] OP_ST    = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_OP    = 7'b0110011;

   logic [31:0] pc_q, pc_e_q, res_w_q;
   logic        vld_e_q, wr_w_q, ld_w_q;
   logic [4:0]  rd_w_q;
   logic [2:0]  f3_w_q;
   logic [1:0]  alo_w_q;
   logic [31:0] rf_q [32];
   logic        halt_q, halt_set;

   logic [6:0]  opc;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  f3;
   logic        is_lui, is_auipc, is_jal, is_jalr, is_br, is_ld, is_st, is_imm, is_op, wr_e;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   logic [31:0] rs1_v, rs2_v, op_b, alu, res, target, ld_val, wb_val, st_data;
   logic [4:0]  sh;
   logic        br_eq, br_lt, br_ltu, br_take, redirect;
   logic [15:0] mem_addr;
   logic [3:0]  mask;
   logic [7:0]  ld_b;
   logic [15:0] ld_h;

   assign opc = ins[6:0];
   assign rd  = ins[11:7];
   assign f3  = ins[14:12];
   assign rs1 = ins[19:15];
   assign rs2 = ins[24:20];

   assign is_lui   = (opc == OP_LUI);
   assign is_auipc = (opc == OP_AUIPC);
   assign is_jal   = (opc == OP_JAL);
   assign is_jalr  = (opc == OP_JALR);
   assign is_br    = (opc == OP_BR);
   assign is_ld    = (opc == OP_LD);
   assign is_st    = (opc == OP_ST);
   assign is_imm   = (opc == OP_IMM);
   assign is_op    = (opc == OP_OP);
   assign wr_e     = (is_lui | is_auipc | is_jal | is_jalr | is_ld | is_imm | is_op) && (rd != 5'd0);

   assign imm_i = {{20{ins[31]}}, ins[31:20]};
   assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
   assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
   assign imm_u = {ins[31:12], 12'h000};
   assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

   // W result, including the load path straight from dat_rd, is what E sees on a forward
   assign ld_b   = dat_rd[{alo_w_q, 3'b000} +: 8];
   assign ld_h   = alo_w_q[1] ? dat_rd[31:16] : dat_rd[15:0];
   always_comb begin
      ld_val = dat_rd;
      case (f3_w_q)
         3'b000:  ld_val = {{24{ld_b[7]}}, ld_b};
         3'b001:  ld_val = {{16{ld_h[15]}}, ld_h};
         3'b100:  ld_val = {24'h0, ld_b};
         3'b101:  ld_val = {16'h0, ld_h};
         default: ld_val = dat_rd;
      endcase
   end
   assign wb_val = ld_w_q ? ld_val : res_w_q;

   always_comb begin
      rs1_v = rf_q[rs1];
      rs2_v = rf_q[rs2];
      if (wr_w_q && (rd_w_q == rs1)) rs1_v = wb_val;
      if (wr_w_q && (rd_w_q == rs2)) rs2_v = wb_val;
      if (rs1 == 5'd0) rs1_v = 32'h0;
      if (rs2 == 5'd0) rs2_v = 32'h0;
   end

   always_comb begin
      op_b = is_op ? rs2_v : imm_i;
      sh   = op_b[4:0];
      alu  = 32'h0;
      case (f3)
         3'b000:  alu = (is_op && ins[30]) ? rs1_v - op_b : rs1_v + op_b;
         3'b001:  alu = rs1_v << sh;
         3'b010:  alu = {31'h0, $signed(rs1_v) < $signed(op_b)};
         3'b011:  alu = {31'h0, rs1_v < op_b};
         3'b100:  alu = rs1_v ^ op_b;
         3'b101:  alu = ins[30] ? $unsigned($signed(rs1_v) >>> sh) : rs1_v >> sh;
         3'b110:  alu = rs1_v | op_b;
         default: alu = rs1_v & op_b;
      endcase
   end

   always_comb begin
      res = alu;
      if (is_lui)                res = imm_u;
      else if (is_auipc)         res = pc_e_q + imm_u;
      else if (is_jal | is_jalr) res = pc_e_q + 32'd4;
   end

   assign br_eq  = (rs1_v == rs2_v);
   assign br_lt  = ($signed(rs1_v) < $signed(rs2_v));
   assign br_ltu = (rs1_v < rs2_v);
   always_comb begin
      case (f3)
         3'b000:  br_take = br_eq;
         3'b001:  br_take = !br_eq;
         3'b100:  br_take = br_lt;
         3'b101:  br_take = !br_lt;
         3'b110:  br_take = br_ltu;
         3'b111:  br_take = !br_ltu;
         default: br_take = 1'b0;
      endcase
   end

   always_comb begin
      target = pc_e_q + imm_b;
      if (is_jal)       target = pc_e_q + imm_j;
      else if (is_jalr) target = (rs1_v + imm_i) & ~32'h1;
   end
   assign redirect = vld_e_q && (is_jal || is_jalr || (is_br && br_take));

   // Only the low 16 address bits reach the SRAM, so the upper sum bits are never formed
   assign mem_addr = rs1_v[15:0] + (is_st ? imm_s[15:0] : imm_i[15:0]);
   always_comb begin
      case (f3[1:0])
         2'b00:   begin mask = 4'b0001 << mem_addr[1:0];          st_data = {4{rs2_v[7:0]}};  end
         2'b01:   begin mask = 4'b0011 << {mem_addr[1], 1'b0};    st_data = {2{rs2_v[15:0]}}; end
         default: begin mask = 4'b1111;                           st_data = rs2_v;            end
      endcase
   end

   assign dat_a  = (vld_e_q && (is_ld || is_st)) ? mem_addr : 16'h0;
   assign dat_we = (vld_e_q && is_st) ? mask : 4'h0;
   assign dat_re = (vld_e_q && is_ld) ? mask : 4'h0;
   assign dat_wd = (vld_e_q && is_st) ? st_data : 32'h0;

   assign ins_a = pc_q[15:0];
   assign ins_e = !rstn && !halt_q;

`ifdef ILLEGAL_HALT_EN
   logic known_op;
   assign known_op = is_lui | is_auipc | is_jal | is_jalr | is_br | is_ld | is_st | is_imm | is_op
                   | (opc == 7'b0001111);
   assign halt_set = vld_e_q && !known_op && !halt_q;
   always_ff @(posedge clk or posedge rstn) begin
      if (rstn)          halt_q <= 1'b0;
      else if (halt_set) halt_q <= 1'b1;
   end
`else
   assign halt_set = 1'b0;
   assign halt_q   = 1'b0;
`endif

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         pc_q    <= RESET_PC;
         pc_e_q  <= RESET_PC;
         vld_e_q <= 1'b0;
         wr_w_q  <= 1'b0;
         ld_w_q  <= 1'b0;
         rd_w_q  <= 5'd0;
         f3_w_q  <= 3'd0;
         alo_w_q <= 2'd0;
         res_w_q <= 32'h0;
         for (int i = 0; i < 32; i++) rf_q[i] <= 32'h0;
      end else begin
         if (!halt_q && !halt_set) pc_q <= redirect ? target : pc_q + 32'd4;
         pc_e_q  <= pc_q;
         vld_e_q <= ins_e && !redirect && !halt_set;
         wr_w_q  <= vld_e_q && wr_e && !halt_set;
         ld_w_q  <= is_ld;
         rd_w_q  <= rd;
         f3_w_q  <= f3;
         alo_w_q <= mem_addr[1:0];
         res_w_q <= res;
         if (wr_w_q && !halt_q) rf_q[rd_w_q] <= wb_val;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_riscv_core.sv
`default_nettype none
// tb_riscv_core: directed programs on behavioural instruction/data SRAMs, checked against hand-computed values.
module tb_riscv_core;
   localparam logic [31:0] NOP   = 32'h0000_0013;
   localparam logic [31:0] ECALL = 32'h0000_0073;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic [15:0] ins_a, dat_a;
   logic        ins_e;
   logic [31:0] ins, dat_wd, dat_rd;
   logic [3:0]  dat_we, dat_re;

   logic [31:0] imem [16384];
   logic [31:0] dmem [16384];

   logic [15:0] tr_a  [64];
   logic        tr_e  [64];
   logic [3:0]  tr_we [64];
   logic [3:0]  tr_re [64];
   logic [15:0] tr_da [64];
   logic [31:0] tr_wd [64];

   int errors = 0;
   int checks = 0;

   riscv_core #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rstn(rstn),
      .ins_a(ins_a), .ins_e(ins_e), .ins(ins),
      .dat_a(dat_a), .dat_we(dat_we), .dat_wd(dat_wd), .dat_re(dat_re), .dat_rd(dat_rd)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (ins_e) ins <= imem[ins_a[15:2]];
   end

   always @(posedge clk) begin
      for (int l = 0; l < 4; l++)
         if (dat_we[l]) dmem[dat_a[15:2]][8*l +: 8] <= dat_wd[8*l +: 8];
      if (|dat_re) dat_rd <= dmem[dat_a[15:2]];
   end

   function automatic logic [31:0] i_t(input logic [31:0] imm, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
      return {imm[11:0], rs1, f3, rd, op};
   endfunction
   function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                       input logic [2:0] f3, input logic [4:0] rd);
      return {f7, rs2, rs1, f3, rd, 7'b0110011};
   endfunction
   function automatic logic [31:0] s_t(input logic [31:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] b_t(input logic [31:0] imm, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] j_t(input logic [31:0] imm, input logic [4:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
   endfunction

   task automatic load_nops();
      for (int i = 0; i < 16384; i++) imem[i] = NOP;
   endtask

   // Hold reset, release on a falling edge, then record outputs 1 time unit after each falling edge
   task automatic run_prog(input int n);
      rstn = 1'b1;
      repeat (2) @(negedge clk);
      rstn = 1'b0;
      for (int c = 0; c < n; c++) begin
         #1;
         tr_a[c]  = ins_a;
         tr_e[c]  = ins_e;
         tr_we[c] = dat_we;
         tr_re[c] = dat_re;
         tr_da[c] = dat_a;
         tr_wd[c] = dat_wd;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      checks++; if (ins_e !== 1'b0)   begin errors++; $display("FAIL reset_ins_e: got %b want 0", ins_e); end
      checks++; if (ins_a !== 16'h0)  begin errors++; $display("FAIL reset_ins_a: got %h want 0000", ins_a); end
      checks++; if (dat_we !== 4'h0)  begin errors++; $display("FAIL reset_dat_we: got %b want 0000", dat_we); end
      checks++; if (dat_re !== 4'h0)  begin errors++; $display("FAIL reset_dat_re: got %b want 0000", dat_re); end
      checks++; if (dat_a !== 16'h0)  begin errors++; $display("FAIL reset_dat_a: got %h want 0000", dat_a); end
      checks++; if (dat_wd !== 32'h0) begin errors++; $display("FAIL reset_dat_wd: got %h want 0", dat_wd); end
   endtask

   task automatic test_fetch();
      logic [15:0] exp_a [4];
      exp_a[0] = 16'h0; exp_a[1] = 16'h4; exp_a[2] = 16'h8; exp_a[3] = 16'hC;
      load_nops();
      run_prog(6);
      for (int c = 0; c < 4; c++) begin
         checks++; if (tr_a[c] !== exp_a[c]) begin errors++; $display("FAIL fetch_ins_a[%0d]: got %h want %h", c, tr_a[c], exp_a[c]); end
         checks++; if (tr_e[c] !== 1'b1)     begin errors++; $display("FAIL fetch_ins_e[%0d]: got %b want 1", c, tr_e[c]); end
      end
   endtask

   task automatic test_back_to_back();
      load_nops();
      imem[0] = i_t(32'd5, 5'd0, 3'd0, 5'd1, 7'b0010011);
      imem[1] = i_t(-32'sd7, 5'd1, 3'd0, 5'd2, 7'b0010011);
      imem[2] = r_t(7'b0100000, 5'd2, 5'd1, 3'd0, 5'd3);
      imem[3] = i_t(32'd9, 5'd0, 3'd0, 5'd0, 7'b0010011);
      imem[4] = r_t(7'd0, 5'd0, 5'd0, 3'd0, 5'd12);
      imem[5] = i_t(32'd3, 5'd2, 3'd5, 5'd13, 7'b0010011) | 32'h4000_0000;
      imem[6] = r_t(7'd0, 5'd2, 5'd1, 3'd2, 5'd14);
      run_prog(12);
      checks++; if (dut.rf_q[1] !== 32'd5)         begin errors++; $display("FAIL b2b_x1: got %h want 00000005", dut.rf_q[1]); end
      checks++; if (dut.rf_q[2] !== 32'hFFFFFFFE)  begin errors++; $display("FAIL b2b_x2: got %h want fffffffe", dut.rf_q[2]); end
      checks++; if (dut.rf_q[3] !== 32'd7)         begin errors++; $display("FAIL b2b_x3: got %h want 00000007", dut.rf_q[3]); end
      checks++; if (dut.rf_q[12] !== 32'd0)        begin errors++; $display("FAIL b2b_x0_write: got %h want 0", dut.rf_q[12]); end
      checks++; if (dut.rf_q[13] !== 32'hFFFFFFFF) begin errors++; $display("FAIL b2b_srai: got %h want ffffffff", dut.rf_q[13]); end
      checks++; if (dut.rf_q[14] !== 32'd0)        begin errors++; $display("FAIL b2b_slt: got %h want 0", dut.rf_q[14]); end
   endtask

   task automatic test_mem();
      load_nops();
      imem[0] = i_t(32'd5, 5'd0, 3'd0, 5'd1, 7'b0010011);
      imem[1] = i_t(-32'sd7, 5'd1, 3'd0, 5'd2, 7'b0010011);
      imem[2] = s_t(32'h10, 5'd1, 5'd0, 3'd2);
      imem[3] = s_t(32'h13, 5'd2, 5'd0, 3'd0);
      imem[4] = i_t(32'h10, 5'd0, 3'd2, 5'd4, 7'b0000011);
      imem[5] = r_t(7'd0, 5'd0, 5'd4, 3'd0, 5'd5);
      imem[6] = i_t(32'h13, 5'd0, 3'd0, 5'd6, 7'b0000011);
      imem[7] = i_t(32'h13, 5'd0, 3'd4, 5'd7, 7'b0000011);
      imem[8] = i_t(32'h12, 5'd0, 3'd1, 5'd8, 7'b0000011);
      run_prog(14);
      checks++; if (tr_we[3] !== 4'b1111)       begin errors++; $display("FAIL sw_we: got %b want 1111", tr_we[3]); end
      checks++; if (tr_da[3] !== 16'h0010)      begin errors++; $display("FAIL sw_addr: got %h want 0010", tr_da[3]); end
      checks++; if (tr_wd[3] !== 32'd5)         begin errors++; $display("FAIL sw_wd: got %h want 00000005", tr_wd[3]); end
      checks++; if (tr_re[3] !== 4'b0000)       begin errors++; $display("FAIL sw_re: got %b want 0000", tr_re[3]); end
      checks++; if (tr_we[4] !== 4'b1000)       begin errors++; $display("FAIL sb_we: got %b want 1000", tr_we[4]); end
      checks++; if (tr_wd[4] !== 32'hFEFEFEFE)  begin errors++; $display("FAIL sb_wd: got %h want fefefefe", tr_wd[4]); end
      checks++; if (tr_re[5] !== 4'b1111)       begin errors++; $display("FAIL lw_re: got %b want 1111", tr_re[5]); end
      checks++; if (tr_re[7] !== 4'b1000)       begin errors++; $display("FAIL lb_re: got %b want 1000", tr_re[7]); end
      checks++; if (tr_re[9] !== 4'b1100)       begin errors++; $display("FAIL lh_re: got %b want 1100", tr_re[9]); end
      checks++; if (dmem[4] !== 32'hFE000005)   begin errors++; $display("FAIL mem_word: got %h want fe000005", dmem[4]); end
      checks++; if (dut.rf_q[4] !== 32'hFE000005) begin errors++; $display("FAIL lw_x4: got %h want fe000005", dut.rf_q[4]); end
      checks++; if (dut.rf_q[5] !== 32'hFE000005) begin errors++; $display("FAIL load_use_x5: got %h want fe000005", dut.rf_q[5]); end
      checks++; if (dut.rf_q[6] !== 32'hFFFFFFFE) begin errors++; $display("FAIL lb_x6: got %h want fffffffe", dut.rf_q[6]); end
      checks++; if (dut.rf_q[7] !== 32'h000000FE) begin errors++; $display("FAIL lbu_x7: got %h want 000000fe", dut.rf_q[7]); end
      checks++; if (dut.rf_q[8] !== 32'hFFFFFE00) begin errors++; $display("FAIL lh_x8: got %h want fffffe00", dut.rf_q[8]); end
   endtask

   task automatic test_branch();
      load_nops();
      imem[0] = i_t(32'd5, 5'd0, 3'd0, 5'd1, 7'b0010011);
      imem[1] = i_t(-32'sd7, 5'd1, 3'd0, 5'd2, 7'b0010011);
      imem[2] = b_t(32'd8, 5'd2, 5'd1, 3'd6);
      imem[3] = i_t(32'd1, 5'd0, 3'd0, 5'd9, 7'b0010011);
      imem[4] = i_t(32'd2, 5'd0, 3'd0, 5'd10, 7'b0010011);
      imem[5] = b_t(32'd8, 5'd2, 5'd1, 3'd0);
      imem[6] = i_t(32'd6, 5'd0, 3'd0, 5'd14, 7'b0010011);
      imem[7] = b_t(32'd8, 5'd1, 5'd2, 3'd5);
      imem[8] = i_t(32'd7, 5'd0, 3'd0, 5'd15, 7'b0010011);
      run_prog(16);
      checks++; if (tr_a[3] !== 16'h000C)   begin errors++; $display("FAIL bltu_pre_a: got %h want 000c", tr_a[3]); end
      checks++; if (tr_a[4] !== 16'h0010)   begin errors++; $display("FAIL bltu_target_a: got %h want 0010", tr_a[4]); end
      checks++; if (dut.rf_q[9] !== 32'd0)  begin errors++; $display("FAIL bltu_squash_x9: got %h want 0", dut.rf_q[9]); end
      checks++; if (dut.rf_q[10] !== 32'd2) begin errors++; $display("FAIL bltu_target_x10: got %h want 2", dut.rf_q[10]); end
      checks++; if (dut.rf_q[14] !== 32'd6) begin errors++; $display("FAIL beq_not_taken_x14: got %h want 6", dut.rf_q[14]); end
      checks++; if (dut.rf_q[15] !== 32'd7) begin errors++; $display("FAIL bge_signed_x15: got %h want 7", dut.rf_q[15]); end
   endtask

   task automatic test_jump();
      load_nops();
      imem[16] = j_t(32'h20, 5'd1);
      imem[17] = i_t(32'd1, 5'd11, 3'd0, 5'd11, 7'b0010011);
      imem[24] = i_t(32'd1, 5'd1, 3'd0, 5'd0, 7'b1100111);
      imem[25] = i_t(32'd1, 5'd0, 3'd0, 5'd9, 7'b0010011);
      run_prog(25);
      checks++; if (tr_a[18] !== 16'h0060)     begin errors++; $display("FAIL jal_target_a: got %h want 0060", tr_a[18]); end
      checks++; if (tr_a[20] !== 16'h0044)     begin errors++; $display("FAIL jalr_target_a: got %h want 0044", tr_a[20]); end
      checks++; if (dut.rf_q[1] !== 32'h44)    begin errors++; $display("FAIL jal_link_x1: got %h want 00000044", dut.rf_q[1]); end
      checks++; if (dut.rf_q[11] !== 32'd1)    begin errors++; $display("FAIL jal_squash_x11: got %h want 1", dut.rf_q[11]); end
      checks++; if (dut.rf_q[9] !== 32'd0)     begin errors++; $display("FAIL jalr_squash_x9: got %h want 0", dut.rf_q[9]); end
   endtask

   task automatic test_reset_midrun();
      load_nops();
      for (int i = 0; i < 64; i++) imem[i] = s_t(32'h20, 5'd0, 5'd0, 3'd2);
      run_prog(4);
      #1;
      checks++; if (dat_we !== 4'b1111) begin errors++; $display("FAIL midrun_pre_we: got %b want 1111", dat_we); end
      rstn = 1'b1;
      #1;
      checks++; if (dat_we !== 4'h0)  begin errors++; $display("FAIL midrun_we_drop: got %b want 0000", dat_we); end
      checks++; if (ins_e !== 1'b0)   begin errors++; $display("FAIL midrun_ins_e: got %b want 0", ins_e); end
      checks++; if (ins_a !== 16'h0)  begin errors++; $display("FAIL midrun_ins_a: got %h want 0000", ins_a); end
      checks++; if (dat_a !== 16'h0)  begin errors++; $display("FAIL midrun_dat_a: got %h want 0000", dat_a); end
      @(negedge clk);
      rstn = 1'b0;
      #1;
      checks++; if (ins_e !== 1'b1)   begin errors++; $display("FAIL restart_ins_e: got %b want 1", ins_e); end
      checks++; if (dat_we !== 4'h0)  begin errors++; $display("FAIL restart_we: got %b want 0000", dat_we); end
      @(negedge clk);
      #1;
      checks++; if (ins_a !== 16'h4)  begin errors++; $display("FAIL restart_ins_a: got %h want 0004", ins_a); end
   endtask

   task automatic test_system();
      load_nops();
      imem[1] = ECALL;
      imem[2] = i_t(32'd4, 5'd0, 3'd0, 5'd13, 7'b0010011);
      run_prog(10);
`ifdef ILLEGAL_HALT_EN
      checks++; if (tr_e[2] !== 1'b1)        begin errors++; $display("FAIL halt_pre_ins_e: got %b want 1", tr_e[2]); end
      checks++; if (tr_e[3] !== 1'b0)        begin errors++; $display("FAIL halt_ins_e: got %b want 0", tr_e[3]); end
      checks++; if (tr_e[9] !== 1'b0)        begin errors++; $display("FAIL halt_sticky: got %b want 0", tr_e[9]); end
      checks++; if (tr_a[9] !== 16'h0008)    begin errors++; $display("FAIL halt_pc_frozen: got %h want 0008", tr_a[9]); end
      checks++; if (dut.rf_q[13] !== 32'd0)  begin errors++; $display("FAIL halt_no_write: got %h want 0", dut.rf_q[13]); end
`else
      checks++; if (tr_e[3] !== 1'b1)        begin errors++; $display("FAIL ecall_nop_ins_e: got %b want 1", tr_e[3]); end
      checks++; if (tr_a[9] !== 16'h0024)    begin errors++; $display("FAIL ecall_nop_pc: got %h want 0024", tr_a[9]); end
      checks++; if (dut.rf_q[13] !== 32'd4)  begin errors++; $display("FAIL ecall_nop_next: got %h want 4", dut.rf_q[13]); end
`endif
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_back_to_back();
      test_mem();
      test_branch();
      test_jump();
      test_reset_midrun();
      test_system();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
